// File: rtl/pulse_meas_if.sv
// Result port of the pulse measurement block: one valid/ready channel carrying
// the high time, the period and the saturation flag of a completed measurement.
interface pulse_meas_if #(
  parameter int CNT_W = 16
);
  logic             meas_valid;
  logic             meas_ready;
  logic [CNT_W-1:0] high_width;
  logic [CNT_W:0]   period;
  logic             meas_sat;

  // Handshake: the producer raises meas_valid with a result and holds the payload
  // stable until the cycle where meas_valid && meas_ready, which is the transfer.
  modport master (
    output meas_valid,
    output high_width,
    output period,
    output meas_sat,
    input  meas_ready
  );

  modport slave (
    input  meas_valid,
    input  high_width,
    input  period,
    input  meas_sat,
    output meas_ready
  );
endinterface

// File: rtl/pulse_meas.sv
// Measures high time and period of a pulse from edge strobes and offers each
// completed rising->falling->rising measurement on a valid/ready result port.
module pulse_meas #(
  parameter int CNT_W = 16
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        en,
  input  logic        clr,
  input  logic        pos_edge,
  input  logic        neg_edge,
  pulse_meas_if.master meas,
  output logic        ovf,
  output logic        err,
  output logic [1:0]  dbg_state_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HIGH = 2'd1,
    S_LOW  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] hcnt_q, hcnt_d;
  logic [CNT_W-1:0] lcnt_q, lcnt_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] high_q, high_d;
  logic [CNT_W:0]   period_q, period_d;
  logic             sat_q, sat_d;
  logic             ovf_q, ovf_d;
  logic             err_q, err_d;

  logic both_edges;
  logic cmpl;
  logic xfer;
  logic load;
  logic drop;

  assign both_edges = en && pos_edge && neg_edge;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= S_IDLE;
      hcnt_q   <= '0;
      lcnt_q   <= '0;
      valid_q  <= 1'b0;
      high_q   <= '0;
      period_q <= '0;
      sat_q    <= 1'b0;
      ovf_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      hcnt_q   <= hcnt_d;
      lcnt_q   <= lcnt_d;
      valid_q  <= valid_d;
      high_q   <= high_d;
      period_q <= period_d;
      sat_q    <= sat_d;
      ovf_q    <= ovf_d;
      err_q    <= err_d;
    end
  end

  // Counters saturate and hold; a stuck input never times the FSM out.
  always_comb begin
    state_d = state_q;
    hcnt_d  = hcnt_q;
    lcnt_d  = lcnt_q;
    cmpl    = 1'b0;
    if (!en || both_edges) begin
      state_d = S_IDLE;
      hcnt_d  = '0;
      lcnt_d  = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (pos_edge) begin
            state_d = S_HIGH;
            hcnt_d  = CNT_ONE;
            lcnt_d  = '0;
          end
        end
        S_HIGH: begin
          if (neg_edge) begin
            state_d = S_LOW;
            lcnt_d  = CNT_ONE;
          end else if (hcnt_q != CNT_MAX) begin
            hcnt_d = hcnt_q + CNT_ONE;
          end
        end
        S_LOW: begin
          if (pos_edge) begin
            cmpl    = 1'b1;
            state_d = S_HIGH;
            hcnt_d  = CNT_ONE;
            lcnt_d  = '0;
          end else if (lcnt_q != CNT_MAX) begin
            lcnt_d = lcnt_q + CNT_ONE;
          end
        end
        default: begin
          state_d = S_IDLE;
          hcnt_d  = '0;
          lcnt_d  = '0;
        end
      endcase
    end
  end

  // A completion loads only into an empty or simultaneously drained output slot.
  always_comb begin
    xfer     = valid_q && meas.meas_ready;
    load     = cmpl && (!valid_q || xfer);
    drop     = cmpl && valid_q && !meas.meas_ready;
    valid_d  = load || (valid_q && !xfer);
    high_d   = high_q;
    period_d = period_q;
    sat_d    = sat_q;
    if (load) begin
      high_d   = hcnt_q;
      period_d = {1'b0, hcnt_q} + {1'b0, lcnt_q};
      sat_d    = (hcnt_q == CNT_MAX) || (lcnt_q == CNT_MAX);
    end
    ovf_d = (ovf_q && !clr) || drop;
    err_d = (err_q && !clr) || both_edges;
  end

  assign meas.meas_valid = valid_q;
  assign meas.high_width = high_q;
  assign meas.period     = period_q;
  assign meas.meas_sat   = sat_q;
  assign ovf             = ovf_q;
  assign err             = err_q;
  assign dbg_state_o     = state_q;

endmodule

// File: doc/pulse_meas.md
Name: pulse_meas

Overview:
- Consumes the single-cycle pos_edge/neg_edge strobes from the edge-capture stage and measures the high time and period of the monitored pulse in clk cycles.
- Each completed measurement (rising edge -> falling edge -> next rising edge) is presented on a valid/ready output port for the downstream consumer.
- Sticky status flags report dropped results and illegal strobe combinations.

Parameters:
- CNT_W, 16, width of the high-time and low-time counters; each counter saturates at 2^CNT_W-1.

Ports:
- clk  in  1  clock; all logic on posedge
- rstn  in  1  reset; asynchronous, active-low
- en  in  1  measurement enable
- clr  in  1  synchronous clear of the sticky ovf and err flags
- pos_edge  in  1  rising-edge strobe, one cycle wide
- neg_edge  in  1  falling-edge strobe, one cycle wide
- meas_valid  out  1  result available
- meas_ready  in  1  consumer accepts result
- high_width  out  CNT_W  high time in cycles
- period  out  CNT_W+1  high time + low time in cycles
- meas_sat  out  1  a counter saturated during this measurement
- ovf  out  1  sticky: a result was dropped
- err  out  1  sticky: pos_edge and neg_edge asserted in the same cycle

Behaviour:
- Reset: all outputs 0, FSM in IDLE, internal counters 0.
- FSM states: IDLE, HIGH, LOW.
  - IDLE: on pos_edge, set hcnt<=1 and go to HIGH. neg_edge is ignored in IDLE.
  - HIGH: on neg_edge, set lcnt<=1 and go to LOW. Otherwise hcnt<=hcnt+1, saturating. pos_edge is ignored in HIGH.
  - LOW: on pos_edge, complete the measurement, set hcnt<=1 and go to HIGH (back-to-back measurement). Otherwise lcnt<=lcnt+1, saturating. neg_edge is ignored in LOW.
- Completion values:
  - high_width=hcnt, period=hcnt+lcnt, computed at CNT_W+1 bits with no overflow.
  - meas_sat=1 if either counter reached 2^CNT_W-1 during this measurement.
  - Results appear on the outputs the cycle after the completing pos_edge.
- Saturation: a counter at its maximum holds that value; the FSM does not time out.
- Output handshake:
  - meas_valid rises with a loaded result.
  - high_width, period and meas_sat hold stable while meas_valid=1.
  - Transfer occurs when meas_valid&&meas_ready; meas_valid falls the next cycle unless a new result loads in that same cycle.
- Boundary conditions:
  - Completion while meas_valid=1 and meas_ready=0: the new result is dropped, the held result is kept, and ovf<=1.
  - Completion in the same cycle as a transfer: the new result loads and meas_valid stays 1. No ovf.
  - pos_edge&&neg_edge in any state: err<=1, FSM goes to IDLE, counters cleared. No result is produced.
  - en=0: FSM forced to IDLE, counters cleared, strobes ignored. A pending output result and its handshake are unaffected.
  - Re-enable: the first measurement starts at the next pos_edge.
  - clr: ovf<=0 and err<=0. If a set condition occurs in the same cycle, set wins.
  - Reset asserted mid-measurement: everything returns to reset values immediately; any pending result is lost.

Test Plan:
- en=1, meas_ready=1; pos_edge@t0, neg_edge@t3, pos_edge@t8 -> meas_valid=1 @t9 with high_width=3, period=8, meas_sat=0; meas_valid=0 @t10.
- Continuous waveform, 2 cycles high / 2 low, meas_ready=1 -> a result every 4 cycles, each with high_width=2, period=4; no gaps after the first.
- meas_ready=0; two complete measurements (3/5 then 4/4) -> the output holds high_width=3, period=8 and ovf=1. Then meas_ready=1 -> one transfer; pulse clr -> ovf=0.
- CNT_W=4; high time 20 cycles, low 2 -> high_width=15, period=17, meas_sat=1.
- pos_edge=neg_edge=1 during HIGH -> err=1, no result, FSM in IDLE. A following 3/5 pulse measures correctly.
- rstn low while in LOW with meas_valid=1 -> all outputs 0 immediately. After release, a neg_edge alone produces nothing; a full 3/5 pulse then measures correctly.
